// File: rtl/alu_mdu.sv
// RV32I/RV32M execution unit: single-cycle base ALU plus radix-2 iterative
// multiply/divide, with valid/ready handshakes on the request and result sides.
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic [4:0]      i_alu_op,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_alu_data,
    output logic            o_busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] LAST_STEP = SHW'(XLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_r;
    logic [SHW-1:0]      cnt_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     mcand_r;
    logic                neg_r;
    logic                sel_hi_r;
    logic                valid_r;
    logic                busy_r;
    logic [XLEN-1:0]     data_r;

    function automatic logic [XLEN-1:0] base_alu(input logic [4:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            5'h00:   base_alu = a + b;
            5'h01:   base_alu = a - b;
            5'h02:   base_alu = a << sh;
            5'h03:   base_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            5'h04:   base_alu = {{(XLEN-1){1'b0}}, (a < b)};
            5'h05:   base_alu = a ^ b;
            5'h06:   base_alu = a >> sh;
            5'h07:   base_alu = $unsigned($signed(a) >>> sh);
            5'h08:   base_alu = a | b;
            5'h09:   base_alu = a & b;
            default: base_alu = '0;
        endcase
    endfunction

    logic                is_mul_s, is_div_s, is_rem_s;
    logic                a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]     a_mag_s, b_mag_s;
    logic                div_zero_s, div_ovf_s, accept_s;
    logic [XLEN:0]       mul_sum_s, div_diff_s;
    logic [2*XLEN-1:0]   acc_nxt_s, prod_s;
    logic [XLEN-1:0]     half_s, fin_s;

    assign o_ready    = i_rst_n & ~i_flush &
                        ((state_r == ST_IDLE) | ((state_r == ST_DONE) & i_ready));
    assign accept_s   = i_valid & o_ready;
    assign o_valid    = valid_r;
    assign o_busy     = busy_r;
    assign o_alu_data = data_r;

    // Request decode: which operands are signed, their magnitudes, and the divide special cases.
    always_comb begin
        is_mul_s   = (i_alu_op[4:2] == 3'b100);
        is_div_s   = (i_alu_op[4:2] == 3'b101);
        is_rem_s   = i_alu_op[1];
        a_signed_s = is_mul_s ? (i_alu_op[1:0] != 2'b11) : (is_div_s & ~i_alu_op[0]);
        b_signed_s = is_mul_s ? ~i_alu_op[1]            : (is_div_s & ~i_alu_op[0]);
        a_neg_s    = a_signed_s & i_op_a[XLEN-1];
        b_neg_s    = b_signed_s & i_op_b[XLEN-1];
        a_mag_s    = a_neg_s ? -i_op_a : i_op_a;
        b_mag_s    = b_neg_s ? -i_op_b : i_op_b;
        div_zero_s = (i_op_b == {XLEN{1'b0}});
        div_ovf_s  = ~i_alu_op[0] & (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) &
                     (i_op_b == {XLEN{1'b1}});
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide, plus final fix-up.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
        div_diff_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, mcand_r};
        if (state_r == ST_MUL) begin
            acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end else if (!div_diff_s[XLEN]) begin
            acc_nxt_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt_s = {acc_r[2*XLEN-2:XLEN-1], acc_r[XLEN-2:0], 1'b0};
        end
        prod_s = neg_r ? -acc_nxt_s : acc_nxt_s;
        half_s = sel_hi_r ? acc_nxt_s[2*XLEN-1:XLEN] : acc_nxt_s[XLEN-1:0];
        if (state_r == ST_MUL) begin
            fin_s = sel_hi_r ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end else begin
            fin_s = neg_r ? -half_s : half_s;
        end
    end

    // Control FSM and datapath registers; flush outranks any new request or retirement.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            acc_r    <= '0;
            mcand_r  <= '0;
            neg_r    <= 1'b0;
            sel_hi_r <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            data_r   <= '0;
        end else if (i_flush) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else if (accept_s) begin
            cnt_r <= '0;
            if (is_mul_s) begin
                state_r  <= ST_MUL;
                valid_r  <= 1'b0;
                busy_r   <= 1'b1;
                acc_r    <= {{XLEN{1'b0}}, b_mag_s};
                mcand_r  <= a_mag_s;
                neg_r    <= a_neg_s ^ b_neg_s;
                sel_hi_r <= (i_alu_op[1:0] != 2'b00);
            end else if (is_div_s && div_zero_s) begin
                state_r <= ST_DONE;
                valid_r <= 1'b1;
                busy_r  <= 1'b0;
                data_r  <= is_rem_s ? i_op_a : {XLEN{1'b1}};
            end else if (is_div_s && div_ovf_s) begin
                state_r <= ST_DONE;
                valid_r <= 1'b1;
                busy_r  <= 1'b0;
                data_r  <= is_rem_s ? {XLEN{1'b0}} : i_op_a;
            end else if (is_div_s) begin
                state_r  <= ST_DIV;
                valid_r  <= 1'b0;
                busy_r   <= 1'b1;
                acc_r    <= {{XLEN{1'b0}}, a_mag_s};
                mcand_r  <= b_mag_s;
                neg_r    <= is_rem_s ? a_neg_s : (a_neg_s ^ b_neg_s);
                sel_hi_r <= is_rem_s;
            end else begin
                state_r <= ST_DONE;
                valid_r <= 1'b1;
                busy_r  <= 1'b0;
                data_r  <= base_alu(i_alu_op, i_op_a, i_op_b);
            end
        end else begin
            case (state_r)
                ST_MUL, ST_DIV: begin
                    acc_r <= acc_nxt_s;
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == LAST_STEP) begin
                        state_r <= ST_DONE;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                        data_r  <= fin_s;
                        cnt_r   <= '0;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
